// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// No logic here; latency and backpressure are properties of muldiv_unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the controller (master) and muldiv_unit (slave).
// start is honoured only while the unit is idle; busy/done tell the controller when to stall.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (output start, op, a, b, input hi, lo, busy, done, dz);
  modport slave  (input start, op, a, b, output hi, lo, busy, done, dz);

endinterface

// File: rtl/muldiv_step.sv
// One shift-add (multiply, LSB-first) or restoring shift-subtract (divide, MSB-first) iteration.
// Purely combinational, zero latency, no flow control.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] part_rem;
  logic [WIDTH:0] trial;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opnd};
    // Divide keeps {remainder, dividend/quotient} in acc; the extra top bit carries the borrow.
    part_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = part_rem - {1'b0, opnd};
    q_bit    = 1'b0;
    acc_nxt  = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      q_bit   = ~trial[WIDTH];
      // Quotient LSB is left clear here and merged in by the caller from q_bit.
      acc_nxt = {(q_bit ? trial[WIDTH-1:0] : part_rem[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU on magnitudes with sign fix-up; done pulses 34 cycles after start (2 on divide-by-zero).
// start is sampled only in IDLE; requests while busy or in the done cycle are dropped, not queued.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  io
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, mag_a, mag_b;
  op_e                op_in;
  logic               in_div, in_signed, sign_a, sign_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (step_acc),
    .q_bit   (q_bit)
  );

  always_comb begin
    op_in     = op_e'(io.op);
    in_div    = (op_in == OP_DIVU) || (op_in == OP_DIV);
    in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    sign_a    = in_signed & io.a[WIDTH-1];
    sign_b    = in_signed & io.b[WIDTH-1];
    mag_a     = sign_a ? -io.a : io.a;
    mag_b     = sign_b ? -io.b : io.b;
    prod      = neg_res_q ? -acc_q : acc_q;
    quo       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          is_div_d  = in_div;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          dz_d      = 1'b0;
          cnt_d     = '0;
          state_d   = CALC;
          if (in_div) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
          // Divide by zero skips the iterations and parks the raw dividend for hi.
          if (in_div && (io.b == '0)) begin
            dz_d    = 1'b1;
            acc_d   = {io.a, {WIDTH{1'b1}}};
            state_d = FIX;
          end
        end
      end
      CALC: begin
        acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        if (dz_q) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end else if (is_div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign io.hi   = hi_q;
  assign io.lo   = lo_q;
  assign io.dz   = dz_q;
  assign io.busy = (state_q == CALC) || (state_q == FIX);
  assign io.done = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit: a driver pushes expected results into a scoreboard,
// a negedge monitor pops and compares on every done pulse and checks busy/hold behaviour every cycle.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   n_live = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  exp_t sb[$];

  muldiv_if #(.WIDTH(32)) dut_if ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (dut_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, truncating signed division.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int issue);
    exp_t        e;
    longint      sa, sb_, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.dz = 1'b0;
    e.issue = issue;
    p = '0;
    case (op)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = sa * sb_;
      2'd2: if (b != 0) p = {a % b, a / b};
      default: if (b != 0) begin
        q = sa / sb_;
        r = sa % sb_;
        p = {r[31:0], q[31:0]};
      end
    endcase
    if (op[1] && b == 0) begin
      e.dz = 1'b1;
      p = {a, 32'hFFFF_FFFF};
    end
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.lat = e.dz ? 2 : 34;
    return e;
  endfunction

  // Called in the posedge time slot; leaves start low after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    #1;
    dut_if.start = 1'b1;
    dut_if.op = op;
    dut_if.a = a;
    dut_if.b = b;
    sb.push_back(model(op, a, b, cyc));
    n_live++;
    exp_done = done_cnt + 1;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    dut_if.op = 2'($urandom);
    dut_if.a = $urandom;
    dut_if.b = $urandom;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done_cnt < exp_done && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (done_cnt < exp_done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected one within 100 cycles (cycle %0d)", cyc);
      n_live -= sb.size();
      sb.delete();
      exp_done = done_cnt;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dut_if.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(dut_if.done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(dut_if.hi), 64'(e.hi));
          chk("lo", 64'(dut_if.lo), 64'(e.lo));
          chk("dz", 64'(dut_if.dz), 64'(e.dz));
          chk("latency", 64'(cyc - e.issue), 64'(e.lat));
          chk("busy_in_done", 64'(dut_if.busy), 64'd0);
          last_hi = e.hi;
          last_lo = e.lo;
        end
      end else begin
        if (sb.size() > 0 && cyc > sb[0].issue)
          chk("busy_during_op", 64'(dut_if.busy), 64'd1);
        else
          chk("busy_idle", 64'(dut_if.busy), 64'd0);
        chk("hi_hold", 64'(dut_if.hi), 64'(last_hi));
        chk("lo_hold", 64'(dut_if.lo), 64'(last_lo));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected $finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    rst_n = 1'b0;
    dut_if.start = 1'b0;
    dut_if.op = 2'd0;
    dut_if.a = '0;
    dut_if.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", 64'(dut_if.hi), 64'd0);
    chk("rst_lo", 64'(dut_if.lo), 64'd0);
    chk("rst_busy", 64'(dut_if.busy), 64'd0);
    chk("rst_done", 64'(dut_if.done), 64'd0);
    chk("rst_dz", 64'(dut_if.dz), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    issue(2'd1, 32'hFFFF_FFF9, 32'd3);         wait_done();
    issue(2'd3, 32'hFFFF_FD10, 32'd7);         wait_done();
    issue(2'd2, 32'd1080, 32'd7);              wait_done();
    issue(2'd2, 32'd333, 32'd0);               wait_done();
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    issue(2'd3, 32'hFFFF_FFF0, 32'd0);         wait_done();

    // Second start while busy must be dropped.
    issue(2'd0, 32'd98, 32'd720);
    repeat (4) @(posedge clk);
    #1;
    dut_if.start = 1'b1;
    dut_if.op = 2'd2;
    dut_if.a = 32'd1080;
    dut_if.b = 32'd7;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    wait_done();
    // start held through the done cycle must not be accepted either.
    issue(2'd2, 32'd100, 32'd9);
    while (done_cnt < exp_done - 1 || !dut_if.busy) @(negedge clk);
    while (!dut_if.done) @(negedge clk);
    dut_if.start = 1'b1;
    @(negedge clk);
    dut_if.start = 1'b0;
    repeat (40) @(posedge clk);

    // Reset in the middle of CALC.
    issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    n_live -= sb.size();
    sb.delete();
    last_hi = '0;
    last_lo = '0;
    #1;
    chk("midrst_hi", 64'(dut_if.hi), 64'd0);
    chk("midrst_lo", 64'(dut_if.lo), 64'd0);
    chk("midrst_busy", 64'(dut_if.busy), 64'd0);
    chk("midrst_done", 64'(dut_if.done), 64'd0);
    chk("midrst_dz", 64'(dut_if.dz), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    issue(2'd0, 32'd3, 32'd5); wait_done();

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      if (sel == 1) rb = $urandom_range(0, 15);
      if (sel == 2) ra = $urandom_range(0, 1000);
      if (sel == 3) rb = 32'hFFFF_FFFF;
      if (sel == 4) ra = 32'h8000_0000;
      issue(rop, ra, rb);
      wait_done();
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(n_live));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
